// File: rtl/qar_pkg.sv
// Shared QAR-Core definitions: ALU op encodings, RV32I opcode/funct fields,
// and the OP/OP-IMM decoder used by the issue stage.
package qar_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    illegal;
  } dec_t;

  // Anything outside the supported ALU subset decodes as an illegal ADD bubble.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3        = instr[14:12];
    f7        = instr[31:25];
    d.op      = ALU_ADD;
    d.use_imm = 1'b0;
    d.illegal = 1'b1;
    if (instr[6:0] == OPC_OP) begin
      case (f3)
        F3_ADD: begin
          if (f7 == F7_BASE) begin d.op = ALU_ADD; d.illegal = 1'b0; end
          else if (f7 == F7_ALT) begin d.op = ALU_SUB; d.illegal = 1'b0; end
        end
        F3_SLL: if (f7 == F7_BASE) begin d.op = ALU_SLL; d.illegal = 1'b0; end
        F3_SRL: if (f7 == F7_BASE) begin d.op = ALU_SRL; d.illegal = 1'b0; end
        F3_XOR: if (f7 == F7_BASE) begin d.op = ALU_XOR; d.illegal = 1'b0; end
        F3_OR:  if (f7 == F7_BASE) begin d.op = ALU_OR;  d.illegal = 1'b0; end
        F3_AND: if (f7 == F7_BASE) begin d.op = ALU_AND; d.illegal = 1'b0; end
        default: d.illegal = 1'b1;
      endcase
    end else if (instr[6:0] == OPC_OP_IMM) begin
      d.use_imm = 1'b1;
      case (f3)
        F3_ADD: begin d.op = ALU_ADD; d.illegal = 1'b0; end
        F3_XOR: begin d.op = ALU_XOR; d.illegal = 1'b0; end
        F3_OR:  begin d.op = ALU_OR;  d.illegal = 1'b0; end
        F3_AND: begin d.op = ALU_AND; d.illegal = 1'b0; end
        F3_SLL: if (f7 == F7_BASE) begin d.op = ALU_SLL; d.illegal = 1'b0; end
        F3_SRL: if (f7 == F7_BASE) begin d.op = ALU_SRL; d.illegal = 1'b0; end
        default: d.illegal = 1'b1;
      endcase
    end
    if (d.illegal) begin
      d.op      = ALU_ADD;
      d.use_imm = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/qar_regfile.sv
// 32 x XLEN register file: two async read ports plus a debug port, one
// synchronous write port, x0 hardwired to zero, cleared by async reset.
module qar_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic [4:0]      da,
  output logic [XLEN-1:0] dd,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem_reg [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_reg[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      mem_reg[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : mem_reg[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : mem_reg[ra2];
  assign dd  = (da  == 5'd0) ? '0 : mem_reg[da];

endmodule

// File: rtl/alu_issue.sv
// Decode/issue/writeback front end for the QAR-Core ALU: EX stage drives the
// external ALU, RET stage holds the retire record; EX result forwards to decode.
module alu_issue
  import qar_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RETIRE_PC_W = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            ret_valid,
  input  logic            ret_ready,
  output logic [4:0]      ret_rd,
  output logic [XLEN-1:0] ret_data,
  output logic            ret_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic            ex_valid_reg, ex_illegal_reg;
  alu_op_e         ex_op_reg;
  logic [XLEN-1:0] ex_a_reg, ex_b_reg;
  logic [4:0]      ex_rd_reg;
  logic            ret_valid_reg, ret_illegal_reg;
  logic [4:0]      ret_rd_reg;
  logic [XLEN-1:0] ret_data_reg;

  dec_t            dec_next;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rf_rd1, rf_rd2, src1, src2, ex_a_next, ex_b_next;
  logic            fwd1, fwd2, advance, accept, rf_we;
  logic            unused_params;

  assign unused_params = ^{RETIRE_PC_W[0]};

  assign dec_next = decode(instr);
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];

  assign advance     = ex_valid_reg & (~ret_valid_reg | ret_ready);
  assign instr_ready = ~ex_valid_reg | advance;
  assign accept      = instr_valid & instr_ready;
  assign rf_we       = advance & ~ex_illegal_reg & (ex_rd_reg != 5'd0);

  qar_regfile #(.XLEN(XLEN)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .rd1 (rf_rd1),
    .ra2 (rs2),
    .rd2 (rf_rd2),
    .da  (dbg_addr),
    .dd  (dbg_data),
    .we  (rf_we),
    .wa  (ex_rd_reg),
    .wd  (alu_result)
  );

  // The EX result is not in the register file until it advances, so a
  // dependent instruction in decode takes it straight from the ALU.
  assign fwd1 = ex_valid_reg & ~ex_illegal_reg & (ex_rd_reg != 5'd0) & (ex_rd_reg == rs1);
  assign fwd2 = ex_valid_reg & ~ex_illegal_reg & (ex_rd_reg != 5'd0) & (ex_rd_reg == rs2);
  assign src1 = fwd1 ? alu_result : rf_rd1;
  assign src2 = fwd2 ? alu_result : rf_rd2;

  always_comb begin
    ex_a_next = '0;
    ex_b_next = '0;
    if (!dec_next.illegal) begin
      ex_a_next = src1;
      ex_b_next = dec_next.use_imm ? {{(XLEN-12){instr[31]}}, instr[31:20]} : src2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_illegal_reg <= 1'b0;
      ex_op_reg      <= ALU_ADD;
      ex_a_reg       <= '0;
      ex_b_reg       <= '0;
      ex_rd_reg      <= '0;
    end else if (accept) begin
      ex_valid_reg   <= 1'b1;
      ex_illegal_reg <= dec_next.illegal;
      ex_op_reg      <= dec_next.op;
      ex_a_reg       <= ex_a_next;
      ex_b_reg       <= ex_b_next;
      ex_rd_reg      <= instr[11:7];
    end else if (advance) begin
      ex_valid_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_reg   <= 1'b0;
      ret_rd_reg      <= '0;
      ret_data_reg    <= '0;
      ret_illegal_reg <= 1'b0;
    end else if (advance) begin
      ret_valid_reg   <= 1'b1;
      ret_rd_reg      <= ex_rd_reg;
      ret_data_reg    <= ex_illegal_reg ? '0 : alu_result;
      ret_illegal_reg <= ex_illegal_reg;
    end else if (ret_ready) begin
      ret_valid_reg   <= 1'b0;
    end
  end

  assign alu_op_a    = ex_a_reg;
  assign alu_op_b    = ex_b_reg;
  assign alu_op      = ex_op_reg;
  assign ret_valid   = ret_valid_reg;
  assign ret_rd      = ret_rd_reg;
  assign ret_data    = ret_data_reg;
  assign ret_illegal = ret_illegal_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: behavioural ALU, reference register model,
// and a retire scoreboard fed at instruction acceptance.
module tb_alu_issue;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_op_a, alu_op_b, alu_result;
  logic [3:0]  alu_op;
  logic        ret_valid, ret_ready, ret_illegal;
  logic [4:0]  ret_rd, dbg_addr;
  logic [31:0] ret_data, dbg_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [31:0] rf_m [32];

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32), .RETIRE_PC_W(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op_a    (alu_op_a),
    .alu_op_b    (alu_op_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .ret_valid   (ret_valid),
    .ret_ready   (ret_ready),
    .ret_rd      (ret_rd),
    .ret_data    (ret_data),
    .ret_illegal (ret_illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU on the other side of the interface
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_op_a + alu_op_b;
      4'd1:    alu_result = alu_op_a - alu_op_b;
      4'd2:    alu_result = alu_op_a & alu_op_b;
      4'd3:    alu_result = alu_op_a | alu_op_b;
      4'd4:    alu_result = alu_op_a ^ alu_op_b;
      4'd5:    alu_result = alu_op_a << alu_op_b[4:0];
      4'd6:    alu_result = alu_op_a >> alu_op_b[4:0];
      default: alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Reference semantics in program order; updates the model register file.
  function automatic exp_t model(input logic [31:0] i);
    exp_t        e;
    logic [31:0] a, b, r;
    logic        ok;
    a  = rf_m[i[19:15]];
    r  = 32'h0;
    ok = 1'b0;
    if (i[6:0] == 7'b0110011) begin
      b = rf_m[i[24:20]];
      case ({i[31:25], i[14:12]})
        10'b0000000_000: begin r = a + b; ok = 1'b1; end
        10'b0100000_000: begin r = a - b; ok = 1'b1; end
        10'b0000000_111: begin r = a & b; ok = 1'b1; end
        10'b0000000_110: begin r = a | b; ok = 1'b1; end
        10'b0000000_100: begin r = a ^ b; ok = 1'b1; end
        10'b0000000_001: begin r = a << b[4:0]; ok = 1'b1; end
        10'b0000000_101: begin r = a >> b[4:0]; ok = 1'b1; end
        default: ok = 1'b0;
      endcase
    end else if (i[6:0] == 7'b0010011) begin
      b = {{20{i[31]}}, i[31:20]};
      case (i[14:12])
        3'b000: begin r = a + b; ok = 1'b1; end
        3'b111: begin r = a & b; ok = 1'b1; end
        3'b110: begin r = a | b; ok = 1'b1; end
        3'b100: begin r = a ^ b; ok = 1'b1; end
        3'b001: if (i[31:25] == 7'd0) begin r = a << i[24:20]; ok = 1'b1; end
        3'b101: if (i[31:25] == 7'd0) begin r = a >> i[24:20]; ok = 1'b1; end
        default: ok = 1'b0;
      endcase
    end
    e.rd   = i[11:7];
    e.ill  = ~ok;
    e.data = ok ? r : 32'h0;
    if (ok && i[11:7] != 5'd0) rf_m[i[11:7]] = r;
    return e;
  endfunction

  // Retire monitor: a record is consumed on the next rising edge
  always @(negedge clk) begin
    if (!rst && ret_valid && ret_ready) begin
      chk("retire_expected", {31'h0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("retire rd=%0d data=%h illegal=%0b (exp rd=%0d data=%h illegal=%0b)",
                 ret_rd, ret_data, ret_illegal, e.rd, e.data, e.ill);
        chk("ret_rd", {27'h0, ret_rd}, {27'h0, e.rd});
        chk("ret_data", ret_data, e.data);
        chk("ret_illegal", {31'h0, ret_illegal}, {31'h0, e.ill});
      end
    end
  end

  task automatic issue(input logic [31:0] i, output int waited);
    exp_t e;
    waited      = 0;
    instr       = i;
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    chk("issue_handshake", {31'h0, instr_ready}, 32'h1);
    if (instr_ready) begin
      @(posedge clk);
      e = model(i);
      sb.push_back(e);
      #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] r, input logic [31:0] v);
    dbg_addr = r;
    #1;
    chk(tag, dbg_data, v);
  endtask

  initial begin
    int          w;
    logic [31:0] held_a;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    ret_ready   = 1'b1;
    dbg_addr    = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_ret_valid", {31'h0, ret_valid}, 32'h0);
    chk("rst_alu_op_a", alu_op_a, 32'h0);
    chk("rst_alu_op_b", alu_op_b, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_ret_data", ret_data, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First instruction and its latency
    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1), w);
    chk("lat_ex_ret_valid", {31'h0, ret_valid}, 32'h0);
    chk("lat_ex_op_b", alu_op_b, 32'd5);
    @(posedge clk);
    #1;
    chk("lat_ret_valid", {31'h0, ret_valid}, 32'h1);
    chk("lat_ret_data", ret_data, 32'd5);
    dbg_chk("dbg_x1_5", 5'd1, 32'd5);
    drain();

    // Back-to-back dependent chain: 7, 14, 7
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd1), w);
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), w);
    chk("chain_ready_add", w, 32'd0);
    issue(enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3), w);
    chk("chain_ready_sub", w, 32'd0);
    drain();
    dbg_chk("dbg_x3_7", 5'd3, 32'd7);

    // Shifts and sign-extended immediate: 48, 12, 0xFFFFFFFF
    issue(enc_i(12'd3, 5'd0, 3'b000, 5'd1), w);
    issue(enc_i(12'd4, 5'd1, 3'b001, 5'd4), w);
    issue(enc_i(12'd2, 5'd4, 3'b101, 5'd5), w);
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd6), w);
    drain();
    dbg_chk("dbg_x5_12", 5'd5, 32'd12);
    dbg_chk("dbg_x6_m1", 5'd6, 32'hFFFF_FFFF);

    // Illegal SLT / SRAI leave x7 untouched
    issue(enc_i(12'd42, 5'd0, 3'b000, 5'd7), w);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7), w);
    issue(enc_i(12'h401, 5'd4, 3'b101, 5'd7), w);
    issue(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd9), w);
    drain();
    dbg_chk("dbg_x7_kept", 5'd7, 32'd42);

    // Backpressure: two issued, third blocked while RET is held
    ret_ready = 1'b0;
    issue(enc_i(12'd100, 5'd0, 3'b000, 5'd10), w);
    issue(enc_r(7'h00, 5'd10, 5'd10, 3'b000, 5'd11), w);
    instr       = enc_r(7'h00, 5'd10, 5'd11, 3'b000, 5'd12);
    instr_valid = 1'b1;
    held_a      = alu_op_a;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_instr_ready", {31'h0, instr_ready}, 32'h0);
      chk("stall_ret_valid", {31'h0, ret_valid}, 32'h1);
      chk("stall_ret_data", ret_data, 32'd100);
      chk("stall_alu_op_a", alu_op_a, held_a);
    end
    @(posedge clk);
    #1;
    ret_ready = 1'b1;
    issue(enc_r(7'h00, 5'd10, 5'd11, 3'b000, 5'd12), w);
    drain();
    dbg_chk("dbg_x12_300", 5'd12, 32'd300);

    // Write to x0 retires with data but does not update x0
    issue(enc_i(12'd9, 5'd0, 3'b000, 5'd0), w);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd8), w);
    drain();
    dbg_chk("dbg_x8_0", 5'd8, 32'd0);
    dbg_chk("dbg_x0_0", 5'd0, 32'd0);

    // Async reset with EX and RET both occupied
    ret_ready = 1'b0;
    issue(enc_i(12'd1, 5'd0, 3'b000, 5'd1), w);
    issue(enc_i(12'd2, 5'd0, 3'b100, 5'd2), w);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ret_valid", {31'h0, ret_valid}, 32'h0);
    chk("arst_ret_rd", {27'h0, ret_rd}, 32'h0);
    chk("arst_ret_data", ret_data, 32'h0);
    chk("arst_alu_op_b", alu_op_b, 32'h0);
    chk("arst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("arst_instr_ready", {31'h0, instr_ready}, 32'h1);
    dbg_chk("arst_dbg_x1", 5'd1, 32'h0);
    sb.delete();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ret_ready = 1'b1;
    issue(enc_i(12'd11, 5'd0, 3'b000, 5'd3), w);
    drain();
    dbg_chk("post_rst_x3", 5'd3, 32'd11);
    dbg_chk("post_rst_x12", 5'd12, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Single-issue decode/issue/writeback front end for the QAR-Core ALU. Accepts RV32I OP and OP-IMM instructions over a valid/ready handshake, reads operands from an internal 32x32 register file, drives the combinational ALU (op_a, op_b, alu_op), writes the result back and presents a retire record downstream. It is the control-side producer of the ALU interface, with full-throughput forwarding for back-to-back dependencies.

## Interface
- XLEN, 32, datapath width (fixed at 32; other values unsupported)
- RETIRE_PC_W, 0, reserved, no function
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  block accepts instr this cycle
- instr  in  32  RV32I instruction word
- alu_op_a  out  32  ALU operand A
- alu_op_b  out  32  ALU operand B
- alu_op  out  4  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6
- alu_result  in  32  combinational ALU result for current alu_* outputs
- ret_valid  out  1  retire record valid
- ret_ready  in  1  downstream accepts retire record
- ret_rd  out  5  destination register
- ret_data  out  32  written value (0 if illegal)
- ret_illegal  out  1  instruction was not a supported ALU op
- dbg_addr  in  5  debug register read address
- dbg_data  out  32  combinational register file read (x0 = 0)

## Operation
- Two stages: EX register (decoded op, operands, rd, illegal) and RET register (rd, data, illegal).
- Decode (combinational on instr): opcode 0110011 R-type: funct3 000/funct7 0000000 ADD, 000/0100000 SUB, 111 AND, 110 OR, 100 XOR, 001/0000000 SLL, 101/0000000 SRL. Opcode 0010011 I-type: 000 ADDI, 111 ANDI, 110 ORI, 100 XORI, 001 SLLI (imm[11:5]=0), 101 SRLI (imm[11:5]=0); op_b = sign-extended imm[11:0]. Everything else (SLT*, SRA*, other opcodes/funct7) is illegal.
- Illegal instr: accepted, travels as a bubble with illegal=1, alu_op=ADD, operands 0, no register write, retires with ret_illegal=1, ret_rd=instr[11:7], ret_data=0.
- EX drives alu_op_a/alu_op_b/alu_op directly from its registers.
- advance = ex_valid & (!ret_valid | ret_ready). On advance: RET <= {ex_rd, alu_result, ex_illegal}; register file[ex_rd] <= alu_result when !ex_illegal and ex_rd != 0.
- instr_ready = !ex_valid | advance (combinational).
- Operand read with forwarding: if ex_valid & !ex_illegal & ex_rd != 0 & ex_rd == rsN, operand = alu_result, else regfile[rsN]. x0 always reads 0.
- ret_valid clears on ret_ready when no advance; holds (stable rd/data/illegal) while ret_ready=0.

## Timing
- Reset (async assert, sync-released use): ex_valid=0, ret_valid=0, all EX/RET fields 0, regfile cleared to 0; hence alu_op_a=alu_op_b=0, alu_op=0, ret_rd=0, ret_data=0, ret_illegal=0, instr_ready=1.
- Latency: instr accepted at edge N -> in EX after N; register written and ret_valid=1 after edge N+1 (if RET free).
- Throughput one instr/cycle while ret_ready=1, including dependent chains.
- ret_ready=0 with RET full: EX holds, instr_ready=0 while ex_valid; alu_* outputs stable.
- Reset mid-operation drops EX and RET contents; no partial write.
- Write to x0: retires with ret_rd=0, ret_data=ALU result, regfile unchanged, no forwarding.

## Structure
- Shared package qar_pkg: ALU op encodings (shared with ALU), opcodes OP/OP_IMM, funct3/funct7 constants.
- Sub-module qar_regfile: 32x32, 2 async read ports + debug read, 1 sync write, x0 hardwired 0, async reset clear.

## Test plan
- Reset, then ADDI x1,x0,5 -> ret_valid one cycle after EX, ret_rd=1, ret_data=5, dbg x1=5.
- ADDI x1,x0,7; ADD x2,x1,x1; SUB x3,x2,x1 back-to-back -> ret_data 7, 14, 7; instr_ready stays 1.
- SLLI x4,x1,4 with x1=3 then SRLI x5,x4,2 -> 48, 12; ADDI x6,x0,-1 -> 0xFFFFFFFF.
- SLT x7,x1,x2 and SRAI -> ret_illegal=1, ret_data=0, x7 unchanged.
- Hold ret_ready=0 for 3 cycles across 3 issued instrs -> instr_ready=0 after EX fills, RET stable, correct in-order retire on release.
- ADDI x0,x0,9 then ADD x8,x0,x0 -> x8=0; assert rst with EX and RET full -> all outputs 0 asynchronously, regfile cleared.
